matrix_column_scanner: RTL and testbench
========================================

# matrix_column_scanner

Time-multiplexed driver for the 5x7 LED matrix. It sits directly downstream of the alternate-display stage. It takes that stage's five 7-bit column images and scans them one column at a time onto the physical column-select and row lines, with per-column blanking against ghosting. It also generates the `selector` signal that the alternate-display stage consumes, so the matrix alternates between the state image and the water-level bar every `FRAMES_PER_VIEW` frames.

## Interface
Parameters:
- `CLK_DIVIDER`, 1000: clock cycles per column slot; legal range ≥ 2.
- `BLANK_CYCLES`, 50: cycles at the start of each slot during which rows are forced off; must be < `CLK_DIVIDER`.
- `FRAMES_PER_VIEW`, 100: full 5-column frames per view before `selector` toggles; must be ≥ 1.

Ports:
- `clock`, input, 1: single system clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: scan run enable.
- `column_4` … `column_0`, input, 7 each: column images from the alternate-display stage; bit 6 is the top row.
- `matrix_columns`, output, 5: one-hot column select, active-low; bit n drives physical column n.
- `matrix_rows`, output, 7: row data, active-high, for the selected column.
- `selector`, output, 1: view select to the alternate-display stage; 1 selects the state image, 0 selects the water bar.
- `frame_tick`, output, 1: one-cycle pulse at each frame boundary.

## Operation
- Prescaler `div_cnt` counts 0 … `CLK_DIVIDER`-1 while `enable`=1, then wraps to 0 (terminal count).
- Column index `col_idx` is 3 bits and takes values 0…4.
  - Advances on each terminal count: 0→1→2→3→4→0.
  - Values 5–7 are illegal. If one is ever reached, the block forces index 0 on the next cycle.
- Shadow buffer: five 7-bit registers. All five load simultaneously from `column_4`…`column_0` on the frame-wrap cycle (terminal count with `col_idx`=4). The displayed frame never mixes two input images.
- Frame counter `frame_cnt` counts 0 … `FRAMES_PER_VIEW`-1 and increments on each frame wrap.
  - On the wrap where `frame_cnt`=`FRAMES_PER_VIEW`-1, `frame_cnt` clears and `selector` toggles.
  - The toggle occurs in the same cycle the shadow loads. The new view is therefore latched one frame later, after the alternate-display stage has settled.
- Output decode (registered):
  - `matrix_columns` = ~(1 << `col_idx`).
  - `matrix_rows` = shadow[`col_idx`] when `div_cnt` ≥ `BLANK_CYCLES`, else 7'b0.
- `enable`=0:
  - `div_cnt`, `col_idx`, `frame_cnt`, shadow and `selector` hold.
  - `matrix_columns` = 5'b11111 and `matrix_rows` = 0 from the next cycle.
  - `frame_tick` stays 0.
  - On re-enable, the scan resumes from the held position.
- Simultaneous events: a frame wrap, shadow load and `selector` toggle landing in the same cycle all take effect together. `enable` is sampled in that same cycle; if it is 0, none of them happens.

## Timing
- Reset values, applied one cycle after `reset` is sampled high:
  - `div_cnt`=0, `col_idx`=0, `frame_cnt`=0, shadow=0.
  - `selector`=1, `frame_tick`=0.
  - `matrix_columns`=5'b11111, `matrix_rows`=7'b0.
- Reset mid-scan aborts the current slot immediately and has priority over `enable`.
- First cycle after reset deasserts, with `enable`=1: the shadow loads from the inputs (priming load), so the first frame is not blank. `div_cnt` starts counting.
- Output latency: `matrix_columns`/`matrix_rows` reflect `col_idx`/`div_cnt` of the previous cycle (one-cycle registered decode).
- `frame_tick` is high for exactly one cycle, the cycle after the frame-wrap edge.
- Frame period is 5×`CLK_DIVIDER` cycles. The view period is 5×`CLK_DIVIDER`×`FRAMES_PER_VIEW` cycles.
- Each column is lit for `CLK_DIVIDER`-`BLANK_CYCLES` cycles per slot.

## Test plan
Use `CLK_DIVIDER`=4, `BLANK_CYCLES`=1, `FRAMES_PER_VIEW`=2 unless stated otherwise.
- **Reset values:** assert `reset` for 2 cycles mid-scan → next cycle `matrix_columns`=11111, `matrix_rows`=0, `selector`=1, `frame_tick`=0; the scan restarts at column 0.
- **Scan order and blanking:** inputs column_n = 7'h01<<n, `enable`=1.
  - `matrix_columns` steps 11110, 11101, 11011, 10111, 01111, each for 4 cycles.
  - Rows are 0 for the first cycle of each slot, then 01, 02, 04, 08, 10 for 3 cycles.
- **Tear-free latch:** change all inputs to 7'h7F mid-frame → `matrix_rows` keeps the old values until after the next `frame_tick`, then shows 7F in every column.
- **View toggle:** run 40 cycles → `frame_tick` pulses at cycles 20 and 40 after start (±1 for latency); `selector` goes 1→0 at the second pulse and 0→1 after 40 more cycles.
- **Enable pause:** drop `enable` for 7 cycles during column 2 → outputs blanked next cycle; after re-enable the scan continues in column 2 with the remaining slot count, and `frame_tick` timing shifts by exactly 7 cycles.
- **Illegal index recovery:** force `col_idx`=6 → next cycle index is 0 and `matrix_columns`=11110 the cycle after.

Source files
------------

// File: rtl/matrix_column_scanner.sv
`default_nettype none
// ============================================================================
// Module   : matrix_column_scanner
// Brief    : Time-multiplexed column scanner for a 5x7 LED matrix. Latches
//            five column images into a shadow buffer once per frame, drives
//            one active-low column select at a time with a blanking window at
//            the start of each slot, and toggles the upstream view selector
//            every FRAMES_PER_VIEW frames.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_column_scanner #(
    parameter int CLK_DIVIDER     = 1000,
    parameter int BLANK_CYCLES    = 50,
    parameter int FRAMES_PER_VIEW = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] column_4,
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [4:0] matrix_columns,
    output logic [6:0] matrix_rows,
    output logic       selector,
    output logic       frame_tick
);

    localparam int                 c_DIV_W      = $clog2(CLK_DIVIDER);
    localparam int                 c_FRAME_W    = $clog2(FRAMES_PER_VIEW + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIVIDER - 1);
    localparam logic [c_DIV_W-1:0] c_BLANK      = c_DIV_W'(BLANK_CYCLES);
    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(FRAMES_PER_VIEW - 1);
    localparam logic [2:0]         c_COL_LAST   = 3'd4;

    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [2:0]           r_col_idx;
    logic [c_FRAME_W-1:0] r_frame_cnt;
    logic [6:0]           r_shadow [5];
    logic                 r_prime;
    logic                 r_selector;
    logic                 r_frame_tick;
    logic [4:0]           r_cols;
    logic [6:0]           r_rows;

    logic                 w_tc;
    logic                 w_col_legal;
    logic                 w_frame_wrap;
    logic                 w_view_wrap;
    logic                 w_load;
    logic [4:0]           w_col_sel_n;
    logic [6:0]           w_row_data;

    // Slot/frame/view boundary strobes; all are qualified by enable so a
    // paused scan can never wrap, load or toggle.
    assign w_tc         = enable && (r_div_cnt == c_DIV_LAST);
    assign w_col_legal  = (r_col_idx <= c_COL_LAST);
    assign w_frame_wrap = w_tc && (r_col_idx == c_COL_LAST);
    assign w_view_wrap  = w_frame_wrap && (r_frame_cnt == c_FRAME_LAST);
    // r_prime makes the first enabled cycle after reset load the shadow so
    // the very first frame is not blank.
    assign w_load       = enable && (r_prime || w_frame_wrap);

    // Decode the column index into the active-low select and pick its shadow row data.
    always_comb begin
        w_col_sel_n = 5'b11111;
        w_row_data  = 7'b0;
        case (r_col_idx)
            3'd0: begin w_col_sel_n = 5'b11110; w_row_data = r_shadow[0]; end
            3'd1: begin w_col_sel_n = 5'b11101; w_row_data = r_shadow[1]; end
            3'd2: begin w_col_sel_n = 5'b11011; w_row_data = r_shadow[2]; end
            3'd3: begin w_col_sel_n = 5'b10111; w_row_data = r_shadow[3]; end
            3'd4: begin w_col_sel_n = 5'b01111; w_row_data = r_shadow[4]; end
            default: begin w_col_sel_n = 5'b11111; w_row_data = 7'b0; end
        endcase
    end

    // Slot prescaler: free-runs 0..CLK_DIVIDER-1 while enabled, holds otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (enable) begin
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        end
    end

    // Column index: advances per slot; an illegal value is pulled back to 0 unconditionally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_col_idx <= 3'd0;
        end else if (!w_col_legal) begin
            r_col_idx <= 3'd0;
        end else if (w_tc) begin
            r_col_idx <= (r_col_idx == c_COL_LAST) ? 3'd0 : r_col_idx + 3'd1;
        end
    end

    // Frame counter and view selector, toggled on the last frame of each view.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_selector  <= 1'b1;
        end else if (w_frame_wrap) begin
            if (w_view_wrap) begin
                r_frame_cnt <= '0;
                r_selector  <= ~r_selector;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Shadow buffer: all five columns captured together so a frame never tears.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                r_shadow[i] <= 7'b0;
            end
            r_prime <= 1'b1;
        end else if (w_load) begin
            r_shadow[0] <= column_0;
            r_shadow[1] <= column_1;
            r_shadow[2] <= column_2;
            r_shadow[3] <= column_3;
            r_shadow[4] <= column_4;
            r_prime     <= 1'b0;
        end
    end

    // Registered outputs: column/row decode, blanking window and frame pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cols       <= 5'b11111;
            r_rows       <= 7'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_wrap;
            if (!enable) begin
                r_cols <= 5'b11111;
                r_rows <= 7'b0;
            end else begin
                r_cols <= w_col_sel_n;
                r_rows <= (r_div_cnt >= c_BLANK) ? w_row_data : 7'b0;
            end
        end
    end

    assign matrix_columns = r_cols;
    assign matrix_rows    = r_rows;
    assign selector       = r_selector;
    assign frame_tick     = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_matrix_column_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_column_scanner
// Brief    : Self-checking bench for matrix_column_scanner with
//            CLK_DIVIDER=4, BLANK_CYCLES=1, FRAMES_PER_VIEW=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_column_scanner;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [6:0] column_4, column_3, column_2, column_1, column_0;
    logic [4:0] matrix_columns;
    logic [6:0] matrix_rows;
    logic       selector;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic       all_on;   // inputs: 1 = every column 7F, 0 = column_n = 1<<n
        logic [4:0] cols;
        logic [6:0] rows;
        logic       tick;
        logic       sel;
    } vec_t;

    vec_t tbl [100];

    matrix_column_scanner #(
        .CLK_DIVIDER    (4),
        .BLANK_CYCLES   (1),
        .FRAMES_PER_VIEW(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .column_4      (column_4),
        .column_3      (column_3),
        .column_2      (column_2),
        .column_1      (column_1),
        .column_0      (column_0),
        .matrix_columns(matrix_columns),
        .matrix_rows   (matrix_rows),
        .selector      (selector),
        .frame_tick    (frame_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected column select for scan position j (cycles since scan start).
    function automatic logic [4:0] exp_cols(input int j);
        logic [4:0] one;
        one = 5'b00001;
        return ~(one << ((j / 4) % 5));
    endfunction

    // Expected rows for scan position j when column_n = 1<<n was latched.
    function automatic logic [6:0] exp_rows_walk(input int j);
        logic [6:0] one;
        one = 7'h01;
        return ((j % 4) == 0) ? 7'h00 : (one << ((j / 4) % 5));
    endfunction

    task automatic set_inputs(input logic all_on);
        column_0 = all_on ? 7'h7F : 7'h01;
        column_1 = all_on ? 7'h7F : 7'h02;
        column_2 = all_on ? 7'h7F : 7'h04;
        column_3 = all_on ? 7'h7F : 7'h08;
        column_4 = all_on ? 7'h7F : 7'h10;
    endtask

    task automatic step;
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at k=%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        // Vector table: entry k is what the outputs must show after edge k.
        for (int k = 0; k < 100; k++) begin
            tbl[k].en     = 1'b1;
            tbl[k].all_on = (k >= 49);
            tbl[k].cols   = exp_cols(k);
            // frame 3 (k 60..79) onward shows the 7F image latched at k=59
            tbl[k].rows   = (k >= 60) ? (((k % 4) == 0) ? 7'h00 : 7'h7F) : exp_rows_walk(k);
            tbl[k].tick   = ((k % 20) == 19);
            tbl[k].sel    = (k >= 39 && k < 79) ? 1'b0 : 1'b1;
        end

        reset  = 1'b1;
        enable = 1'b1;
        set_inputs(1'b0);
        step;
        step;
        chk("reset_cols", -1, 32'(matrix_columns), 32'h1F);
        chk("reset_rows", -1, 32'(matrix_rows), 32'h00);
        chk("reset_sel",  -1, 32'(selector), 32'h1);
        chk("reset_tick", -1, 32'(frame_tick), 32'h0);
        reset = 1'b0;

        // Scan order, blanking, frame ticks, view toggles and tear-free latch.
        for (int k = 0; k < 100; k++) begin
            enable = tbl[k].en;
            set_inputs(tbl[k].all_on);
            step;
            chk("scan_cols", k, 32'(matrix_columns), 32'(tbl[k].cols));
            chk("scan_rows", k, 32'(matrix_rows), 32'(tbl[k].rows));
            chk("scan_tick", k, 32'(frame_tick), 32'(tbl[k].tick));
            chk("scan_sel",  k, 32'(selector), 32'(tbl[k].sel));
        end

        // Run into the next view so selector is 0, then reset mid-scan.
        for (int k = 100; k < 122; k++) step;
        chk("sel_before_reset", 121, 32'(selector), 32'h0);
        reset = 1'b1;
        set_inputs(1'b0);
        for (int r = 0; r < 2; r++) begin
            step;
            chk("midrst_cols", r, 32'(matrix_columns), 32'h1F);
            chk("midrst_rows", r, 32'(matrix_rows), 32'h00);
            chk("midrst_sel",  r, 32'(selector), 32'h1);
            chk("midrst_tick", r, 32'(frame_tick), 32'h0);
        end
        reset = 1'b0;

        // Restart at column 0 with the priming load (1<<n image) visible at once.
        for (int k = 0; k < 10; k++) begin
            step;
            chk("restart_cols", k, 32'(matrix_columns), 32'(exp_cols(k)));
            chk("restart_rows", k, 32'(matrix_rows), 32'(exp_rows_walk(k)));
        end

        // Pause for 7 cycles inside column 2.
        enable = 1'b0;
        for (int k = 10; k < 17; k++) begin
            step;
            chk("pause_cols", k, 32'(matrix_columns), 32'h1F);
            chk("pause_rows", k, 32'(matrix_rows), 32'h00);
            chk("pause_tick", k, 32'(frame_tick), 32'h0);
        end
        enable = 1'b1;
        for (int k = 17; k < 31; k++) begin
            step;
            chk("resume_cols", k, 32'(matrix_columns), 32'(exp_cols(k - 7)));
            chk("resume_rows", k, 32'(matrix_rows), 32'(exp_rows_walk(k - 7)));
            chk("resume_tick", k, 32'(frame_tick), 32'(((k - 7) % 20) == 19));
        end

        // Illegal column index recovery.
        force dut.r_col_idx = 3'd6;
        #1;
        release dut.r_col_idx;
        step;
        chk("illegal_cols_blank", 0, 32'(matrix_columns), 32'h1F);
        step;
        chk("illegal_cols_recover", 1, 32'(matrix_columns), 32'h1E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
